// File: rtl/atm_keypad_frontend.sv
// -----------------------------------------------------------------------------
// atm_keypad_frontend
//
// Keypad entry stage that sits directly in front of the ATM core. A serial
// stream of key codes is assembled into one transaction (language, account
// number, PIN, operation, amount, new PIN), which is then offered to the core
// on a valid/ready handshake. Digit-range limits, CANCEL, CLEAR and an
// inactivity timeout are enforced here.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   key_valid  in   1   one-cycle strobe qualifying key_code
//   key_code   in   4   0-9 digit, A ENTER, B CANCEL, C CLEAR, D-F illegal
//   req_ready  in   1   ATM core accepts the transaction
//   req_valid  out  1   transaction fields valid
//   language   out  1   language select
//   acc_num    out  11  account number (0..2047)
//   pin        out  14  PIN (0..9999)
//   operation  out  3   operation code
//   amount     out  14  amount, 0 when the operation needs none
//   new_pin    out  14  new PIN, 0 unless operation == OP_NEWPIN
//   fsm_state  out  3   current state encoding (debug)
//   key_err    out  1   one-cycle pulse when a key is rejected
//   timeout    out  1   one-cycle pulse on an inactivity abort
// -----------------------------------------------------------------------------
module atm_keypad_frontend #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter logic [7:0]  OP_AMOUNT_MASK = 8'b0000_0110,
   parameter logic [2:0]  OP_NEWPIN      = 3'd3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        req_ready,
   output logic        req_valid,
   output logic        language,
   output logic [10:0] acc_num,
   output logic [13:0] pin,
   output logic [2:0]  operation,
   output logic [13:0] amount,
   output logic [13:0] new_pin,
   output logic [2:0]  fsm_state,
   output logic        key_err,
   output logic        timeout
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCT   = 3'd1,
      S_PIN    = 3'd2,
      S_OPER   = 3'd3,
      S_AMNT   = 3'd4,
      S_NEWPIN = 3'd5,
      S_SEND   = 3'd6
   } state_t;

   localparam logic [3:0]  KEY_ENTER  = 4'hA;
   localparam logic [3:0]  KEY_CANCEL = 4'hB;
   localparam logic [3:0]  KEY_CLEAR  = 4'hC;
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

   // Decimal shift-in of one digit; 17 bits holds 9999*10+9 without wrap.
   function automatic logic [16:0] append_digit(input logic [13:0] val,
                                                input logic [3:0]  dig);
      return (17'(val) * 17'd10) + 17'(dig);
   endfunction

   // Largest legal value of the numeric field being edited in a given state.
   function automatic logic [16:0] field_max(input state_t st);
      return (st == S_ACCT) ? 17'd2047 : 17'd9999;
   endfunction

   state_t      state_q, state_n;
   logic [15:0] timer_q, timer_n;
   logic [2:0]  cnt_q, cnt_n;
   logic        req_valid_q, req_valid_n;
   logic        language_q, language_n;
   logic [10:0] acc_q, acc_n;
   logic [13:0] pin_q, pin_n;
   logic [2:0]  oper_q, oper_n;
   logic [13:0] amount_q, amount_n;
   logic [13:0] new_pin_q, new_pin_n;
   logic        key_err_q, key_err_n;
   logic        timeout_q, timeout_n;

   logic [13:0] cur_val;
   logic [16:0] cand;
   logic        timed;
   state_t      dest;

   // State register: every output is taken straight from a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         cnt_q       <= '0;
         req_valid_q <= 1'b0;
         language_q  <= 1'b0;
         acc_q       <= '0;
         pin_q       <= '0;
         oper_q      <= '0;
         amount_q    <= '0;
         new_pin_q   <= '0;
         key_err_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_n;
         timer_q     <= timer_n;
         cnt_q       <= cnt_n;
         req_valid_q <= req_valid_n;
         language_q  <= language_n;
         acc_q       <= acc_n;
         pin_q       <= pin_n;
         oper_q      <= oper_n;
         amount_q    <= amount_n;
         new_pin_q   <= new_pin_n;
         key_err_q   <= key_err_n;
         timeout_q   <= timeout_n;
      end
   end

   // Next-state and field update logic.
   always_comb begin
      state_n     = state_q;
      cnt_n       = cnt_q;
      req_valid_n = req_valid_q;
      language_n  = language_q;
      acc_n       = acc_q;
      pin_n       = pin_q;
      oper_n      = oper_q;
      amount_n    = amount_q;
      new_pin_n   = new_pin_q;
      key_err_n   = 1'b0;
      timeout_n   = 1'b0;
      timer_n     = '0;
      dest        = S_SEND;

      timed = (state_q == S_ACCT) || (state_q == S_PIN) || (state_q == S_OPER) ||
              (state_q == S_AMNT) || (state_q == S_NEWPIN);

      case (state_q)
         S_ACCT:   cur_val = {3'b000, acc_q};
         S_PIN:    cur_val = pin_q;
         S_AMNT:   cur_val = amount_q;
         S_NEWPIN: cur_val = new_pin_q;
         default:  cur_val = '0;
      endcase
      cand = append_digit(cur_val, key_code);

      if (timed && (timer_q == TMO_LAST)) begin
         // Inactivity abort wins over a key arriving in the same cycle.
         state_n     = S_IDLE;
         timeout_n   = 1'b1;
         cnt_n       = '0;
         req_valid_n = 1'b0;
         language_n  = 1'b0;
         acc_n       = '0;
         pin_n       = '0;
         oper_n      = '0;
         amount_n    = '0;
         new_pin_n   = '0;
      end else if (state_q == S_SEND) begin
         // Keys are silently dropped while the transaction is offered.
         if (req_valid_q && req_ready) begin
            state_n     = S_IDLE;
            cnt_n       = '0;
            req_valid_n = 1'b0;
            language_n  = 1'b0;
            acc_n       = '0;
            pin_n       = '0;
            oper_n      = '0;
            amount_n    = '0;
            new_pin_n   = '0;
         end
      end else if (key_valid) begin
         if (state_q == S_IDLE) begin
            if (key_code <= 4'd1) begin
               language_n = key_code[0];
               acc_n      = '0;
               cnt_n      = '0;
               state_n    = S_ACCT;
            end else if (key_code != KEY_CANCEL) begin
               key_err_n = 1'b1;
            end
         end else if (key_code == KEY_CANCEL) begin
            state_n     = S_IDLE;
            cnt_n       = '0;
            req_valid_n = 1'b0;
            language_n  = 1'b0;
            acc_n       = '0;
            pin_n       = '0;
            oper_n      = '0;
            amount_n    = '0;
            new_pin_n   = '0;
         end else if (key_code == KEY_CLEAR) begin
            cnt_n = '0;
            case (state_q)
               S_ACCT:   acc_n     = '0;
               S_PIN:    pin_n     = '0;
               S_OPER:   oper_n    = '0;
               S_AMNT:   amount_n  = '0;
               S_NEWPIN: new_pin_n = '0;
               default:  ;
            endcase
         end else if (key_code == KEY_ENTER) begin
            if (cnt_q == 3'd0) begin
               key_err_n = 1'b1;
            end else begin
               case (state_q)
                  S_ACCT:  dest = S_PIN;
                  S_PIN:   dest = S_OPER;
                  S_OPER:  dest = OP_AMOUNT_MASK[oper_q] ? S_AMNT :
                                  ((oper_q == OP_NEWPIN) ? S_NEWPIN : S_SEND);
                  S_AMNT:  dest = (oper_q == OP_NEWPIN) ? S_NEWPIN : S_SEND;
                  default: dest = S_SEND;
               endcase
               state_n = dest;
               cnt_n   = '0;
               case (dest)
                  S_PIN:    pin_n       = '0;
                  S_AMNT:   amount_n    = '0;
                  S_NEWPIN: new_pin_n   = '0;
                  S_SEND:   req_valid_n = 1'b1;
                  default:  ;
               endcase
            end
         end else if (key_code <= 4'd9) begin
            if (state_q == S_OPER) begin
               if (key_code < 4'd8) begin
                  oper_n = key_code[2:0];
                  cnt_n  = 3'd1;
               end else begin
                  key_err_n = 1'b1;
               end
            end else if ((cand <= field_max(state_q)) && (cnt_q < 3'd4)) begin
               cnt_n = cnt_q + 3'd1;
               case (state_q)
                  S_ACCT:   acc_n     = cand[10:0];
                  S_PIN:    pin_n     = cand[13:0];
                  S_AMNT:   amount_n  = cand[13:0];
                  S_NEWPIN: new_pin_n = cand[13:0];
                  default:  ;
               endcase
            end else begin
               key_err_n = 1'b1;
            end
         end else begin
            key_err_n = 1'b1;
         end
      end

      // Inactivity timer restarts on any key or state change.
      if (key_valid || (state_n != state_q)) begin
         timer_n = '0;
      end else if (timed) begin
         timer_n = timer_q + 16'd1;
      end
   end

   assign req_valid = req_valid_q;
   assign language  = language_q;
   assign acc_num   = acc_q;
   assign pin       = pin_q;
   assign operation = oper_q;
   assign amount    = amount_q;
   assign new_pin   = new_pin_q;
   assign fsm_state = state_q;
   assign key_err   = key_err_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_atm_keypad_frontend.sv
module tb_atm_keypad_frontend;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        req_ready = 1'b0;
   logic        req_valid;
   logic        language;
   logic [10:0] acc_num;
   logic [13:0] pin;
   logic [2:0]  operation;
   logic [13:0] amount;
   logic [13:0] new_pin;
   logic [2:0]  fsm_state;
   logic        key_err;
   logic        timeout;

   int checks = 0;
   int errors = 0;
   logic last_err;

   atm_keypad_frontend #(
      .TIMEOUT_CYCLES(20),
      .OP_AMOUNT_MASK(8'b0000_0110),
      .OP_NEWPIN(3'd3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_valid(key_valid),
      .key_code(key_code),
      .req_ready(req_ready),
      .req_valid(req_valid),
      .language(language),
      .acc_num(acc_num),
      .pin(pin),
      .operation(operation),
      .amount(amount),
      .new_pin(new_pin),
      .fsm_state(fsm_state),
      .key_err(key_err),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One key strobe, sample key_err on the following cycle, then one idle cycle.
   task automatic press(input logic [3:0] k);
      key_code  = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      last_err  = key_err;
      tick();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, 32'(fsm_state), 0);
      check({tag, "_valid"}, 32'(req_valid), 0);
      check({tag, "_lang"},  32'(language), 0);
      check({tag, "_acc"},   32'(acc_num), 0);
      check({tag, "_pin"},   32'(pin), 0);
      check({tag, "_op"},    32'(operation), 0);
      check({tag, "_amt"},   32'(amount), 0);
      check({tag, "_npin"},  32'(new_pin), 0);
   endtask

   initial begin
      int cyc;

      tick();
      tick();
      rst = 1'b0;
      check_idle("rst");
      check("rst_err", 32'(key_err), 0);
      check("rst_tmo", 32'(timeout), 0);

      // Non-0/1 digit in IDLE is rejected.
      press(4'd5);
      check("idle_err", 32'(last_err), 1);
      check("idle_state", 32'(fsm_state), 0);

      // T1 full withdraw
      press(4'd1);
      check("t1_acct_state", 32'(fsm_state), 1);
      press(4'd1); press(4'd2); press(4'd3); press(4'hA);
      press(4'd4); press(4'd3); press(4'd2); press(4'd1); press(4'hA);
      check("t1_oper_state", 32'(fsm_state), 3);
      press(4'd2); press(4'hA);
      check("t1_amnt_state", 32'(fsm_state), 4);
      press(4'd5); press(4'd0); press(4'd0); press(4'hA);
      check("t1_valid", 32'(req_valid), 1);
      check("t1_state", 32'(fsm_state), 6);
      check("t1_lang",  32'(language), 1);
      check("t1_acc",   32'(acc_num), 123);
      check("t1_pin",   32'(pin), 4321);
      check("t1_op",    32'(operation), 2);
      check("t1_amt",   32'(amount), 500);
      check("t1_npin",  32'(new_pin), 0);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check_idle("t1_done");

      // T2 change PIN, core stalls for 5 cycles
      press(4'd0);
      press(4'd7); press(4'hA);
      press(4'd1); press(4'd1); press(4'd1); press(4'd1); press(4'hA);
      press(4'd3); press(4'hA);
      check("t2_npin_state", 32'(fsm_state), 5);
      press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'hA);
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", 32'(req_valid), 1);
         check("t2_hold_npin",  32'(new_pin), 9876);
         check("t2_hold_pin",   32'(pin), 1111);
         tick();
      end
      check("t2_lang", 32'(language), 0);
      check("t2_acc",  32'(acc_num), 7);
      check("t2_op",   32'(operation), 3);
      check("t2_amt",  32'(amount), 0);
      // Keys in SEND are ignored without error.
      press(4'd4);
      check("t2_send_key_err", 32'(last_err), 0);
      check("t2_send_npin", 32'(new_pin), 9876);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      check_idle("t2_done");

      // T3 range checks
      press(4'd1);
      press(4'd2); press(4'd0); press(4'd4);
      check("t3_acc_ok_err", 32'(last_err), 0);
      press(4'd8);
      check("t3_acc_err", 32'(last_err), 1);
      check("t3_acc", 32'(acc_num), 204);
      press(4'hA);
      check("t3_pin_state", 32'(fsm_state), 2);
      press(4'hA);
      check("t3_empty_err", 32'(last_err), 1);
      check("t3_empty_state", 32'(fsm_state), 2);
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      press(4'd5);
      check("t3_pin5_err", 32'(last_err), 1);
      check("t3_pin", 32'(pin), 1234);
      press(4'hD);
      check("t3_illegal_err", 32'(last_err), 1);
      check("t3_illegal_pin", 32'(pin), 1234);
      press(4'hB);
      check("t3_cancel_err", 32'(last_err), 0);
      check_idle("t3_cancel");

      // T4 abort paths: CLEAR in PIN, CANCEL in AMNT
      press(4'd1);
      press(4'd5); press(4'hA);
      press(4'd5); press(4'd5);
      check("t4_pin55", 32'(pin), 55);
      press(4'hC);
      check("t4_clear_pin", 32'(pin), 0);
      check("t4_clear_state", 32'(fsm_state), 2);
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      check("t4_pin_after_clear_err", 32'(last_err), 0);
      press(4'hA);
      check("t4_pin", 32'(pin), 1234);
      check("t4_oper_state", 32'(fsm_state), 3);
      press(4'd8);
      check("t4_op8_err", 32'(last_err), 1);
      press(4'd1); press(4'hA);
      check("t4_amnt_state", 32'(fsm_state), 4);
      press(4'd7);
      check("t4_amt", 32'(amount), 7);
      press(4'hB);
      check("t4_cancel_err", 32'(last_err), 0);
      check_idle("t4_cancel");

      // T5 inactivity timeout after the language key
      press(4'd1);
      check("t5_acct", 32'(fsm_state), 1);
      cyc = 1;
      while (!timeout && cyc < 100) begin
         tick();
         cyc++;
      end
      check("t5_tmo_cycles", 32'(cyc), 20);
      check_idle("t5_tmo");
      tick();
      check("t5_tmo_pulse_end", 32'(timeout), 0);

      // T6 reset while req_valid is high
      press(4'd0);
      press(4'd5); press(4'hA);
      press(4'd1); press(4'hA);
      press(4'd0); press(4'hA);
      check("t6_valid", 32'(req_valid), 1);
      check("t6_acc", 32'(acc_num), 5);
      check("t6_pin", 32'(pin), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("t6_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
